// File: rtl/segre_pkg.sv
// Shared types and defaults for the segre memory-pipeline front end.
package segre_pkg;

  localparam int WORD_SIZE   = 32;
  localparam int REG_SIZE    = 5;
  localparam int HF_PTR      = 4;
  localparam int AGU_DEPTH   = 4;
  localparam int AGU_NUM_BYP = 2;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } memop_data_type_e;

  // One queued memory request, sized for the default configuration.
  typedef struct packed {
    logic [WORD_SIZE-1:0] addr;
    logic [WORD_SIZE-1:0] st_data;
    logic                 rd;
    logic                 wr;
    logic                 sign_ext;
    memop_data_type_e     mem_type;
    logic                 rf_we;
    logic [REG_SIZE-1:0]  rf_waddr;
    logic [HF_PTR-1:0]    instr_id;
    logic                 misaligned;
  } agu_entry_t;

  // A halfword must be 2-byte aligned, a word 4-byte aligned; bytes always fit.
  function automatic logic is_misaligned(memop_data_type_e t, logic [1:0] lo);
    logic m;
    m = 1'b0;
    if (t == HALF && lo[0]) m = 1'b1;
    if (t == WORD && lo != 2'b00) m = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/segre_sync_fifo.sv
// Synchronous valid/ready FIFO with occupancy count and flush.
// Storage is not reset; only pointers and count are.
module segre_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] cnt;
  logic             do_wr;
  logic             do_rd;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rptr];
  assign count   = cnt;

  // Pointer and occupancy control; flush shares the reset path.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_wr) wptr <= wptr + PTR_W'(1);
      if (do_rd) rptr <= rptr + PTR_W'(1);
      unique case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage write; a write during flush lands in a slot that is then discarded.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= wr_data;
  end

endmodule

// File: rtl/segre_agu_queue.sv
// Memory-pipeline front end: address generation, store-data bypass,
// alignment check and a request queue feeding the TL stage.
module segre_agu_queue
  import segre_pkg::*;
#(
  parameter int WORD_SIZE = segre_pkg::WORD_SIZE,
  parameter int REG_SIZE  = segre_pkg::REG_SIZE,
  parameter int ID_SIZE   = HF_PTR,
  parameter int DEPTH     = AGU_DEPTH,
  parameter int NUM_BYP   = AGU_NUM_BYP
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            flush_i,
  input  logic                            in_valid_i,
  output logic                            in_ready_o,
  input  logic [WORD_SIZE-1:0]            src_a_i,
  input  logic [WORD_SIZE-1:0]            src_b_i,
  input  logic [WORD_SIZE-1:0]            st_data_i,
  input  logic [$clog2(NUM_BYP+1)-1:0]    byp_sel_i,
  input  logic [NUM_BYP*WORD_SIZE-1:0]    byp_data_i,
  input  logic                            memop_rd_i,
  input  logic                            memop_wr_i,
  input  logic                            memop_sign_ext_i,
  input  logic                            rf_we_i,
  input  memop_data_type_e                memop_type_i,
  input  logic [REG_SIZE-1:0]             rf_waddr_i,
  input  logic [ID_SIZE-1:0]              instr_id_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [WORD_SIZE-1:0]            out_addr_o,
  output logic [WORD_SIZE-1:0]            out_st_data_o,
  output logic                            out_rd_o,
  output logic                            out_wr_o,
  output logic                            out_sign_ext_o,
  output logic                            out_rf_we_o,
  output memop_data_type_e                out_type_o,
  output logic [REG_SIZE-1:0]             out_rf_waddr_o,
  output logic [ID_SIZE-1:0]              out_instr_id_o,
  output logic                            out_misaligned_o,
  output logic [$clog2(DEPTH):0]          count_o
);

  localparam int SEL_W = $clog2(NUM_BYP+1);

  typedef struct packed {
    logic [WORD_SIZE-1:0] addr;
    logic [WORD_SIZE-1:0] st_data;
    logic                 rd;
    logic                 wr;
    logic                 sign_ext;
    memop_data_type_e     mem_type;
    logic                 rf_we;
    logic [REG_SIZE-1:0]  rf_waddr;
    logic [ID_SIZE-1:0]   instr_id;
    logic                 misaligned;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  logic [WORD_SIZE-1:0] addr_p0;
  logic [WORD_SIZE-1:0] st_sel_p0;
  entry_t               entry_p0;
  logic [ENTRY_W-1:0]   head_raw;
  entry_t               head_p1;
  logic                 full;
  logic                 empty;

  // Enqueue side: everything is resolved before the entry is written.
  assign addr_p0 = src_a_i + src_b_i;

  // Store-data source select; out-of-range selectors fall back to the register file.
  always_comb begin
    st_sel_p0 = st_data_i;
    for (int k = 0; k < NUM_BYP; k++) begin
      if (byp_sel_i == SEL_W'(k + 1)) st_sel_p0 = byp_data_i[k*WORD_SIZE +: WORD_SIZE];
    end
  end

  assign entry_p0.addr       = addr_p0;
  assign entry_p0.st_data    = st_sel_p0;
  assign entry_p0.rd         = memop_rd_i;
  assign entry_p0.wr         = memop_wr_i;
  assign entry_p0.sign_ext   = memop_sign_ext_i;
  assign entry_p0.mem_type   = memop_type_i;
  assign entry_p0.rf_we      = rf_we_i;
  assign entry_p0.rf_waddr   = rf_waddr_i;
  assign entry_p0.instr_id   = instr_id_i;
  assign entry_p0.misaligned = is_misaligned(memop_type_i, addr_p0[1:0]);

  segre_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk_i),
    .rst     (rst_i),
    .flush   (flush_i),
    .wr_en   (in_valid_i),
    .wr_data (entry_p0),
    .rd_en   (out_ready_i),
    .rd_data (head_raw),
    .count   (count_o),
    .full    (full),
    .empty   (empty)
  );

  // Dequeue side: head fields read as zero whenever the queue is empty.
  assign in_ready_o  = !full;
  assign out_valid_o = !empty;
  assign head_p1     = out_valid_o ? entry_t'(head_raw) : entry_t'('0);

  assign out_addr_o       = head_p1.addr;
  assign out_st_data_o    = head_p1.st_data;
  assign out_rd_o         = head_p1.rd;
  assign out_wr_o         = head_p1.wr;
  assign out_sign_ext_o   = head_p1.sign_ext;
  assign out_rf_we_o      = head_p1.rf_we;
  assign out_type_o       = head_p1.mem_type;
  assign out_rf_waddr_o   = head_p1.rf_waddr;
  assign out_instr_id_o   = head_p1.instr_id;
  assign out_misaligned_o = head_p1.misaligned;

endmodule

// File: tb/tb_segre_agu_queue.sv
// Directed bench for segre_agu_queue: vector table plus queue-depth, flush and reset sequences.
module tb_segre_agu_queue;
  import segre_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]            src_a, src_b, st_data;
  logic [1:0]             byp_sel;
  logic [63:0]            byp_data;
  logic                   m_rd, m_wr, m_sx, rf_we;
  memop_data_type_e       m_type;
  logic [4:0]             rf_waddr;
  logic [3:0]             instr_id;
  logic [31:0]            o_addr, o_st;
  logic                   o_rd, o_wr, o_sx, o_we, o_mis;
  memop_data_type_e       o_type;
  logic [4:0]             o_waddr;
  logic [3:0]             o_id;
  logic [2:0]             count;

  int errors = 0;
  int checks = 0;

  segre_agu_queue dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .src_a_i(src_a), .src_b_i(src_b), .st_data_i(st_data),
    .byp_sel_i(byp_sel), .byp_data_i(byp_data),
    .memop_rd_i(m_rd), .memop_wr_i(m_wr), .memop_sign_ext_i(m_sx), .rf_we_i(rf_we),
    .memop_type_i(m_type), .rf_waddr_i(rf_waddr), .instr_id_i(instr_id),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_addr_o(o_addr), .out_st_data_o(o_st),
    .out_rd_o(o_rd), .out_wr_o(o_wr), .out_sign_ext_o(o_sx), .out_rf_we_o(o_we),
    .out_type_o(o_type), .out_rf_waddr_o(o_waddr), .out_instr_id_o(o_id),
    .out_misaligned_o(o_mis), .count_o(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0]      a, b, st;
    logic [1:0]       sel;
    logic [31:0]      slot1;
    memop_data_type_e t;
    logic             rd, wr;
    logic [3:0]       id;
    logic [31:0]      exp_addr, exp_st;
    logic             exp_mis;
  } vec_t;

  vec_t vecs [9];

  task automatic idle_inputs();
    in_valid = 0; flush = 0; src_a = 0; src_b = 0; st_data = 0; byp_sel = 0;
    byp_data = 64'h12345678_DEAD0001; m_rd = 0; m_wr = 0; m_sx = 0; rf_we = 0;
    m_type = BYTE; rf_waddr = 0; instr_id = 0;
  endtask

  task automatic push_id(input logic [3:0] id);
    in_valid = 1; instr_id = id; m_type = WORD; src_a = 32'h100; src_b = {28'h0, id} << 2;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  logic will_enq;
  int   nxt;

  initial begin
    idle_inputs();
    rst = 1; out_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_count", {29'h0, count}, 32'h0);
    chk("rst_addr", o_addr, 32'h0);
    chk("rst_st", o_st, 32'h0);
    chk("rst_id_mis", {27'h0, o_id, o_mis}, 32'h0);

    //               a             b         st            sel   slot1         t     rd wr id  exp_addr      exp_st        mis
    vecs[0] = '{32'h1000,     32'h24, 32'hAAAA0000, 2'd0, 32'h12345678, WORD, 1, 0, 1, 32'h1024,     32'hAAAA0000, 0};
    vecs[1] = '{32'h2000,     32'h0,  32'hAAAA0000, 2'd2, 32'h12345678, WORD, 0, 1, 2, 32'h2000,     32'h12345678, 0};
    vecs[2] = '{32'h2000,     32'h4,  32'hAAAA0000, 2'd1, 32'h12345678, WORD, 0, 1, 3, 32'h2004,     32'hDEAD0001, 0};
    vecs[3] = '{32'h2000,     32'h8,  32'hAAAA0000, 2'd3, 32'h12345678, WORD, 0, 1, 4, 32'h2008,     32'hAAAA0000, 0};
    vecs[4] = '{32'h1000,     32'h1,  32'h0,        2'd0, 32'h12345678, HALF, 1, 0, 5, 32'h1001,     32'h0,        1};
    vecs[5] = '{32'h1000,     32'h2,  32'h0,        2'd0, 32'h12345678, WORD, 1, 0, 6, 32'h1002,     32'h0,        1};
    vecs[6] = '{32'h1000,     32'h3,  32'h0,        2'd0, 32'h12345678, BYTE, 1, 0, 7, 32'h1003,     32'h0,        0};
    vecs[7] = '{32'hFFFFFFFC, 32'h8,  32'h0,        2'd0, 32'h12345678, WORD, 1, 0, 8, 32'h00000004, 32'h0,        0};
    vecs[8] = '{32'h1000,     32'h2,  32'h5,        2'd0, 32'h0BADF00D, HALF, 0, 1, 9, 32'h1002,     32'h5,        0};

    out_ready = 1;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1; src_a = vecs[i].a; src_b = vecs[i].b; st_data = vecs[i].st;
      byp_sel = vecs[i].sel; byp_data = {vecs[i].slot1, 32'hDEAD0001};
      m_type = vecs[i].t; m_rd = vecs[i].rd; m_wr = vecs[i].wr; instr_id = vecs[i].id;
      m_sx = vecs[i].rd; rf_we = vecs[i].rd; rf_waddr = 5'(vecs[i].id + 4'd3);
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), {31'h0, out_valid}, 32'h1);
      chk($sformatf("v%0d_addr", i), o_addr, vecs[i].exp_addr);
      chk($sformatf("v%0d_st", i), o_st, vecs[i].exp_st);
      chk($sformatf("v%0d_mis", i), {31'h0, o_mis}, {31'h0, vecs[i].exp_mis});
      chk($sformatf("v%0d_attr", i), {24'h0, o_rd, o_wr, o_sx, o_we, o_id},
          {24'h0, vecs[i].rd, vecs[i].wr, vecs[i].rd, vecs[i].rd, vecs[i].id});
      chk($sformatf("v%0d_type", i), {30'h0, o_type}, {30'h0, vecs[i].t});
      chk($sformatf("v%0d_waddr", i), {27'h0, o_waddr}, {27'h0, 5'(vecs[i].id + 4'd3)});
      chk($sformatf("v%0d_count", i), {29'h0, count}, 32'h1);
      @(negedge clk);
      chk($sformatf("v%0d_drained", i), {29'h0, count}, 32'h0);
      chk($sformatf("v%0d_zero_addr", i), o_addr, 32'h0);
    end

    // Empty queue with ready asserted stays empty.
    repeat (2) @(negedge clk);
    chk("empty_deq_count", {29'h0, count}, 32'h0);

    // Fill to depth with TL stalled, fifth request held off.
    out_ready = 0;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("fill_ready%0d", k), {31'h0, in_ready}, 32'h1);
      push_id(4'(k));
    end
    in_valid = 1; instr_id = 4; src_a = 32'h100; src_b = 32'h10; m_type = WORD;
    @(negedge clk);
    chk("full_count", {29'h0, count}, 32'h4);
    chk("full_ready", {31'h0, in_ready}, 32'h0);
    chk("full_head", {28'h0, o_id}, 32'h0);
    @(negedge clk);
    chk("hold_count", {29'h0, count}, 32'h4);
    chk("hold_head_id", {28'h0, o_id}, 32'h0);
    chk("hold_head_addr", o_addr, 32'h100);
    out_ready = 1;
    chk("full_no_comb_ready", {31'h0, in_ready}, 32'h0);
    @(negedge clk);
    chk("full_deq_count", {29'h0, count}, 32'h3);
    nxt = 1;
    for (int cyc = 0; cyc < 20 && nxt < 5; cyc++) begin
      if (out_valid) begin
        chk($sformatf("order%0d", nxt), {28'h0, o_id}, 32'(nxt));
        nxt++;
      end
      will_enq = in_valid && in_ready;
      @(posedge clk); #1;
      if (will_enq) in_valid = 0;
      @(negedge clk);
    end
    chk("order_total", 32'(nxt), 32'h5);
    in_valid = 0;
    @(negedge clk);
    chk("drain_count", {29'h0, count}, 32'h0);

    // Flush with a simultaneous enqueue drops everything.
    out_ready = 0;
    @(posedge clk); #1;
    push_id(4'hA); push_id(4'hB); push_id(4'hC);
    @(negedge clk);
    chk("pre_flush_count", {29'h0, count}, 32'h3);
    flush = 1; in_valid = 1; instr_id = 4'hD; out_ready = 1;
    @(posedge clk); #1;
    flush = 0; in_valid = 0; out_ready = 0;
    @(negedge clk);
    chk("flush_count", {29'h0, count}, 32'h0);
    chk("flush_valid", {31'h0, out_valid}, 32'h0);
    chk("flush_id", {28'h0, o_id}, 32'h0);
    push_id(4'h5);
    @(negedge clk);
    chk("post_flush_count", {29'h0, count}, 32'h1);
    chk("post_flush_head", {28'h0, o_id}, 32'h5);

    // Reset mid-operation with a simultaneous enqueue.
    push_id(4'h6); push_id(4'h7);
    @(negedge clk);
    chk("pre_rst_count", {29'h0, count}, 32'h3);
    rst = 1; in_valid = 1; instr_id = 4'hE;
    @(posedge clk); #1;
    rst = 0; in_valid = 0;
    @(negedge clk);
    chk("rst2_count", {29'h0, count}, 32'h0);
    chk("rst2_valid", {31'h0, out_valid}, 32'h0);
    chk("rst2_ready", {31'h0, in_ready}, 32'h1);
    chk("rst2_addr", o_addr, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/segre_agu_queue.md
Name: segre_agu_queue

Overview:
- Parametrised successor of the memory-pipeline front end: address generation, store-data bypass resolution, alignment check and an N-deep request queue in front of the TL stage.
- Replaces the single hazard-stalled latch with a valid/ready FIFO, so ALU-side issue continues while TL is busy with a miss.
- Store-data bypass is generalised to NUM_BYP forwarding sources.
- Adds misalignment flagging and a flush.

Parameters:
- WORD_SIZE, 32, address/data width
- REG_SIZE, 5, register index width
- ID_SIZE, HF_PTR, instruction-ID width
- DEPTH, 4, queue entries; power of two, >=2
- NUM_BYP, 2, number of forwarding data sources

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- flush_i  in  1  discard all queued entries
- in_valid_i  in  1  request present
- in_ready_o  out  1  queue can accept
- src_a_i  in  WORD_SIZE  base operand
- src_b_i  in  WORD_SIZE  offset operand
- st_data_i  in  WORD_SIZE  register-file store data
- byp_sel_i  in  $clog2(NUM_BYP+1)  0 = no bypass; k = byp_data_i slot k-1
- byp_data_i  in  NUM_BYP*WORD_SIZE  forwarding data, slot k at [k*WORD_SIZE +: WORD_SIZE]
- memop_rd_i, memop_wr_i, memop_sign_ext_i, rf_we_i  in  1 each  op attributes
- memop_type_i  in  memop_data_type_e  BYTE/HALF/WORD
- rf_waddr_i  in  REG_SIZE  destination register
- instr_id_i  in  ID_SIZE  instruction ID
- out_valid_o  out  1  head entry valid
- out_ready_i  in  1  TL accepts head
- out_addr_o  out  WORD_SIZE  head address
- out_st_data_o  out  WORD_SIZE  head store data
- out_rd_o, out_wr_o, out_sign_ext_o, out_rf_we_o  out  1 each  head attributes
- out_type_o  out  memop_data_type_e  head size
- out_rf_waddr_o  out  REG_SIZE  head destination
- out_instr_id_o  out  ID_SIZE  head ID
- out_misaligned_o  out  1  head access misaligned
- count_o  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Enqueue when in_valid_i && in_ready_o. Dequeue when out_valid_o && out_ready_i.
- in_ready_o = (count < DEPTH). No combinational path from out_ready_i; when full, a same-cycle dequeue does not free a slot until the next cycle.
- Address = src_a_i + src_b_i, modulo 2^WORD_SIZE (wraps, no overflow flag), computed at enqueue.
- Store data is resolved at enqueue: byp_sel_i = 0 selects st_data_i; k in 1..NUM_BYP selects slot k-1; any value > NUM_BYP selects st_data_i.
- Misaligned = (HALF && addr[0]) || (WORD && addr[1:0] != 0). BYTE is never misaligned. Misaligned entries are still queued and delivered with the flag; no other action is taken.
- Latency: an entry enqueued in cycle N is at the head in N+1 if the queue was empty. No bypass from input to output.
- Pointers wrap modulo DEPTH.
- Simultaneous enqueue and dequeue: count unchanged, both occur.
- Dequeue when empty, or enqueue when full: ignored; state unchanged.
- out_valid_o = (count != 0). All out_* data fields are forced to 0 while out_valid_o = 0.
- flush_i: next cycle count = 0, pointers = 0. It has priority over a same-cycle enqueue and dequeue; the enqueued item is dropped.
- Reset (rst_i=1, sampled at posedge): count = 0, pointers = 0, out_valid_o = 0, in_ready_o = 1, all out_* = 0. Reset mid-operation discards the contents; storage RAM itself need not be reset.
- In-flight state while holding: head outputs are stable while out_valid_o && !out_ready_i.

Decomposition:
- segre_pkg adds agu_entry_t: addr, st_data, rd, wr, sign_ext, type, rf_we, rf_waddr, instr_id, misaligned.
- segre_pkg adds AGU_DEPTH and AGU_NUM_BYP defaults. memop_data_type_e is reused.
- One sub-module, segre_sync_fifo (parametrised on element type/width and DEPTH; provides count, full/empty, flush), holds the entries.
- Adder, bypass mux and alignment check stay in segre_agu_queue.

Test Plan:
- Reset then idle -> out_valid_o=0, in_ready_o=1, count_o=0, all out_* = 0.
- Enqueue WORD, src_a=0x1000, src_b=0x24, rd=1, out_ready_i=1 -> next cycle out_valid_o=1, out_addr_o=0x1024, misaligned=0; count returns to 0 after the accept cycle.
- DEPTH=4, out_ready_i=0, issue 5 enqueues -> in_ready_o drops after the 4th and the 5th is held; then release out_ready_i -> IDs dequeue in order 0,1,2,3,4.
- Store with st_data=0xAAAA0000, byp_sel=2, byp slot1=0x12345678 -> out_st_data_o=0x12345678; byp_sel=0 -> 0xAAAA0000.
- HALF at addr 0x1001 -> misaligned=1. WORD at 0x1002 -> 1. BYTE at 0x1003 -> 0. src_a=0xFFFFFFFC, src_b=8 -> addr 0x00000004.
- 3 entries queued, flush_i asserted together with an in_valid_i enqueue -> next cycle count_o=0, out_valid_o=0, the new item is absent; the same with rst_i yields the reset values.
